jt1943_dwnld: RTL and testbench
===============================

// Module: jt1943_dwnld
// PURPOSE
//  Download-side ROM writer between the MiST ioctl byte stream and SDRAM programming port.
//  Turns byte writes into masked SDRAM writes held until acknowledged, with a 1-entry skid buffer.
//  Diverts the colour/priority PROM region to one-hot on-chip PROM write strobes instead of SDRAM.
//  Flags completion and overruns.
// PARAMETERS
//  PROM_START  22'h1_4000  byte address of first PROM; all lower addresses go to SDRAM
//  PROM_AW     8           address width of each PROM (256 bytes each)
//  PROM_CNT    12          number of PROMs; bytes at or beyond PROM_START+PROM_CNT<<PROM_AW are dropped
// PORTS
//  clk          in   1      system clock (48 MHz)
//  rst          in   1      asynchronous, active-high reset
//  downloading  in   1      high while the ioctl transfer is active
//  ioctl_addr   in   22     byte address of the incoming byte
//  ioctl_data   in   8      incoming byte
//  ioctl_wr     in   1      one-cycle strobe, one byte per strobe
//  prog_addr    out  22     SDRAM word address, equal to ioctl_addr>>1
//  prog_data    out  8      byte to write
//  prog_mask    out  2      active-low byte enable: 2'b10 for even address, 2'b01 for odd address
//  prog_we      out  1      write request; held high until prog_rdy
//  prog_rdy     in   1      SDRAM write accepted; one-cycle pulse
//  prom_addr    out  PROM_AW  address within the selected PROM
//  prom_din     out  8      PROM data
//  prom_we      out  PROM_CNT  one-hot write strobe, one cycle wide
//  dwnld_done   out  1      one-cycle pulse once the last SDRAM write is accepted after downloading falls
//  overrun      out  1      sticky flag: byte lost because main slot and skid slot were both occupied
// BEHAVIOUR
//  Reset values
//   - All outputs are 0 except prog_mask = 2'b11; state is IDLE; skid slot is empty.
//   - Reset mid-write drops any pending write; no dwnld_done is generated.
//  Address decode (on ioctl_wr, registered)
//   - addr < PROM_START: SDRAM path.
//   - Otherwise idx = (addr-PROM_START)>>PROM_AW.
//   - idx < PROM_CNT: on the next cycle, prom_we[idx] = 1, prom_addr = low PROM_AW bits, prom_din = data.
//   - The PROM path never stalls and never uses the skid slot.
//   - idx >= PROM_CNT: byte discarded silently.
//  FSM states: IDLE, WRITE, FLUSH
//   - IDLE, SDRAM byte arrives: load prog_* and raise prog_we on the next cycle; go to WRITE.
//   - WRITE, prog_rdy = 1, skid empty: drop prog_we in the same cycle as the ack is seen registered; go to IDLE.
//   - WRITE, prog_rdy = 1, skid full: on the next cycle load prog_* from skid, keep prog_we high, empty skid.
//   - WRITE, new SDRAM byte arrives: store it in skid if empty, else set overrun and drop the byte.
//   - WRITE, prog_rdy and a new byte in the same cycle: the byte goes to skid, or straight to prog_* if skid was empty.
//     Nothing is lost and overrun is not set.
//   - downloading falls (1->0, edge-detected) with a write pending or skid full: go to FLUSH.
//   - FLUSH: drain the same way as WRITE, ignoring ioctl_wr. When the final prog_rdy arrives, pulse dwnld_done; go to IDLE.
//   - downloading falls in IDLE: dwnld_done pulses on the following cycle.
//   - ioctl_wr with downloading low: ignored.
//   - overrun clears only on reset or on a rising edge of downloading.
//  Throughput and latency
//   - ioctl_wr to prog_we: 1 cycle.
//   - ioctl_wr to prom_we: 1 cycle.
//   - prog_rdy to next prog_we from skid: 1 cycle.
//   - Sustained rate is 1 byte per ack; ioctl bytes arrive at most every 8 clk.
// STRUCTURE
//  - jt1943_dwnld_pkg: state enum {IDLE,WRITE,FLUSH}; mask constants MASK_LO=2'b10, MASK_HI=2'b01, MASK_NONE=2'b11.
//  - Sub-module jt1943_prom_dec: combinational range check plus one-hot index decode (PROM_START, PROM_AW, PROM_CNT).
//    Reused by the simulation ROM loader.
//  - Main module holds the FSM, the prog_* output registers, the skid register, and the downloading edge detector.
// TESTING
//  1. Single byte: ioctl_addr=0x0003, data=0x5A, one ioctl_wr; prog_rdy 4 cycles later.
//     Expect prog_addr=0x0001, mask=2'b01, data=0x5A, prog_we high 4 cycles then low.
//  2. Skid: two SDRAM bytes 2 cycles apart, prog_rdy delayed 6 cycles.
//     Expect the second write presented 1 cycle after the first ack; overrun=0.
//  3. Overrun: three bytes with no prog_rdy.
//     Expect the third dropped and overrun=1 until downloading rises again.
//  4. PROM: addr=PROM_START+0x105, data=0xC3.
//     Expect prom_we=12'b10 for 1 cycle, prom_addr=0x05, prom_din=0xC3, prog_we stays 0.
//  5. Out of range: addr=PROM_START+(12<<8).
//     Expect no prom_we and no prog_we.
//  6. End of download: downloading falls while prog_we high and skid full.
//     Expect both writes complete and dwnld_done to pulse once, 1 cycle after the second prog_rdy.
//     Async rst mid-WRITE: all outputs return to reset values immediately.

Source files
------------

// File: rtl/jt1943_dwnld_pkg.sv
// rtl/jt1943_dwnld_pkg.sv - shared types and constants for the ioctl download writer
package jt1943_dwnld_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        FLUSH = 2'd2
    } state_e;

    localparam int         ADDR_W    = 22;
    localparam logic [1:0] MASK_LO   = 2'b10;
    localparam logic [1:0] MASK_HI   = 2'b01;
    localparam logic [1:0] MASK_NONE = 2'b11;

    // Active-low byte enable for a 16-bit SDRAM word: odd bytes land in the high lane.
    function automatic logic [1:0] byte_mask(input logic odd);
        return odd ? MASK_HI : MASK_LO;
    endfunction

endpackage

// File: rtl/jt1943_prom_dec.sv
// rtl/jt1943_prom_dec.sv - combinational SDRAM/PROM range check and one-hot PROM select
module jt1943_prom_dec #(
    parameter logic [21:0] PROM_START = 22'h1_4000,
    parameter int          PROM_AW    = 8,
    parameter int          PROM_CNT   = 12
) (
    input  logic [21:0]         addr_i,
    output logic                sdram_o,
    output logic                hit_o,
    output logic [PROM_CNT-1:0] sel_o,
    output logic [PROM_AW-1:0]  addr_o
);

    logic [21:0] off;
    logic [21:0] idx;

    always_comb begin
        off     = addr_i - PROM_START;
        idx     = off >> PROM_AW;
        sdram_o = addr_i < PROM_START;
        hit_o   = !sdram_o && (idx < 22'(PROM_CNT));
        addr_o  = off[PROM_AW-1:0];
        sel_o   = '0;
        for (int i = 0; i < PROM_CNT; i++) begin
            sel_o[i] = hit_o && (idx == 22'(i));
        end
    end

endmodule

// File: rtl/jt1943_dwnld.sv
// rtl/jt1943_dwnld.sv - ioctl byte stream to SDRAM programming port and on-chip PROM strobes
module jt1943_dwnld
    import jt1943_dwnld_pkg::*;
#(
    parameter logic [21:0] PROM_START = 22'h1_4000,
    parameter int          PROM_AW    = 8,
    parameter int          PROM_CNT   = 12
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                downloading,
    input  logic [21:0]         ioctl_addr,
    input  logic [7:0]          ioctl_data,
    input  logic                ioctl_wr,
    output logic [21:0]         prog_addr,
    output logic [7:0]          prog_data,
    output logic [1:0]          prog_mask,
    output logic                prog_we,
    input  logic                prog_rdy,
    output logic [PROM_AW-1:0]  prom_addr,
    output logic [7:0]          prom_din,
    output logic [PROM_CNT-1:0] prom_we,
    output logic                dwnld_done,
    output logic                overrun
);

    state_e               state_q, state_d;
    logic                 dl_q;
    logic [21:0]          prog_addr_q, prog_addr_d;
    logic [7:0]           prog_data_q, prog_data_d;
    logic [1:0]           prog_mask_q, prog_mask_d;
    logic                 prog_we_q, prog_we_d;
    logic                 skid_full_q, skid_full_d;
    logic [21:0]          skid_addr_q, skid_addr_d;
    logic [7:0]           skid_data_q, skid_data_d;
    logic [1:0]           skid_mask_q, skid_mask_d;
    logic [PROM_AW-1:0]   prom_addr_q, prom_addr_d;
    logic [7:0]           prom_din_q, prom_din_d;
    logic [PROM_CNT-1:0]  prom_we_q, prom_we_d;
    logic                 done_q, done_d;
    logic                 overrun_q, overrun_d;

    logic                 is_sdram, prom_hit;
    logic [PROM_CNT-1:0]  prom_sel;
    logic [PROM_AW-1:0]   prom_low;
    logic                 wr_ok, sd_wr, prom_wr, ack, fall, rise;
    logic [21:0]          new_addr;
    logic [1:0]           new_mask;

    jt1943_prom_dec #(
        .PROM_START (PROM_START),
        .PROM_AW    (PROM_AW),
        .PROM_CNT   (PROM_CNT)
    ) u_dec (
        .addr_i  (ioctl_addr),
        .sdram_o (is_sdram),
        .hit_o   (prom_hit),
        .sel_o   (prom_sel),
        .addr_o  (prom_low)
    );

    // Bytes are only taken while a transfer is live and not draining.
    assign wr_ok    = ioctl_wr && downloading && (state_q != FLUSH);
    assign sd_wr    = wr_ok && is_sdram;
    assign prom_wr  = wr_ok && prom_hit;
    assign ack      = prog_rdy && prog_we_q;
    assign fall     = dl_q && !downloading;
    assign rise     = !dl_q && downloading;
    assign new_addr = {1'b0, ioctl_addr[21:1]};
    assign new_mask = byte_mask(ioctl_addr[0]);

    always_comb begin
        state_d     = state_q;
        prog_addr_d = prog_addr_q;
        prog_data_d = prog_data_q;
        prog_mask_d = prog_mask_q;
        prog_we_d   = prog_we_q;
        skid_full_d = skid_full_q;
        skid_addr_d = skid_addr_q;
        skid_data_d = skid_data_q;
        skid_mask_d = skid_mask_q;
        prom_addr_d = prom_addr_q;
        prom_din_d  = prom_din_q;
        prom_we_d   = '0;
        done_d      = 1'b0;
        overrun_d   = overrun_q;

        if (prom_wr) begin
            prom_we_d   = prom_sel;
            prom_addr_d = prom_low;
            prom_din_d  = ioctl_data;
        end

        if (rise) overrun_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (sd_wr) begin
                    prog_addr_d = new_addr;
                    prog_data_d = ioctl_data;
                    prog_mask_d = new_mask;
                    prog_we_d   = 1'b1;
                    state_d     = WRITE;
                end
            end
            WRITE, FLUSH: begin
                if (ack) begin
                    if (skid_full_q) begin
                        prog_addr_d = skid_addr_q;
                        prog_data_d = skid_data_q;
                        prog_mask_d = skid_mask_q;
                        skid_full_d = 1'b0;
                        if (sd_wr) begin
                            skid_addr_d = new_addr;
                            skid_data_d = ioctl_data;
                            skid_mask_d = new_mask;
                            skid_full_d = 1'b1;
                        end
                    end else if (sd_wr) begin
                        prog_addr_d = new_addr;
                        prog_data_d = ioctl_data;
                        prog_mask_d = new_mask;
                    end else begin
                        prog_we_d = 1'b0;
                        state_d   = IDLE;
                        if (state_q == FLUSH) done_d = 1'b1;
                    end
                end else if (sd_wr) begin
                    if (!skid_full_q) begin
                        skid_addr_d = new_addr;
                        skid_data_d = ioctl_data;
                        skid_mask_d = new_mask;
                        skid_full_d = 1'b1;
                    end else begin
                        overrun_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // End of transfer: drain whatever is still queued, else report done right away.
        if (fall) begin
            if (prog_we_d) begin
                state_d = FLUSH;
            end else begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            dl_q        <= 1'b0;
            prog_addr_q <= '0;
            prog_data_q <= '0;
            prog_mask_q <= MASK_NONE;
            prog_we_q   <= 1'b0;
            skid_full_q <= 1'b0;
            skid_addr_q <= '0;
            skid_data_q <= '0;
            skid_mask_q <= MASK_NONE;
            prom_addr_q <= '0;
            prom_din_q  <= '0;
            prom_we_q   <= '0;
            done_q      <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            dl_q        <= downloading;
            prog_addr_q <= prog_addr_d;
            prog_data_q <= prog_data_d;
            prog_mask_q <= prog_mask_d;
            prog_we_q   <= prog_we_d;
            skid_full_q <= skid_full_d;
            skid_addr_q <= skid_addr_d;
            skid_data_q <= skid_data_d;
            skid_mask_q <= skid_mask_d;
            prom_addr_q <= prom_addr_d;
            prom_din_q  <= prom_din_d;
            prom_we_q   <= prom_we_d;
            done_q      <= done_d;
            overrun_q   <= overrun_d;
        end
    end

    assign prog_addr  = prog_addr_q;
    assign prog_data  = prog_data_q;
    assign prog_mask  = prog_mask_q;
    assign prog_we    = prog_we_q;
    assign prom_addr  = prom_addr_q;
    assign prom_din   = prom_din_q;
    assign prom_we    = prom_we_q;
    assign dwnld_done = done_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_jt1943_dwnld.sv
// tb/tb_jt1943_dwnld.sv - scoreboard bench for the ioctl download writer
module tb_jt1943_dwnld;

    localparam logic [21:0] PS = 22'h1_4000;

    logic        clk = 1'b0;
    logic        rst;
    logic        downloading;
    logic [21:0] ioctl_addr;
    logic [7:0]  ioctl_data;
    logic        ioctl_wr;
    logic [21:0] prog_addr;
    logic [7:0]  prog_data;
    logic [1:0]  prog_mask;
    logic        prog_we;
    logic        prog_rdy;
    logic [7:0]  prom_addr;
    logic [7:0]  prom_din;
    logic [11:0] prom_we;
    logic        dwnld_done;
    logic        overrun;

    always #5 clk = ~clk;

    jt1943_dwnld #(
        .PROM_START (PS),
        .PROM_AW    (8),
        .PROM_CNT   (12)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .downloading (downloading),
        .ioctl_addr  (ioctl_addr),
        .ioctl_data  (ioctl_data),
        .ioctl_wr    (ioctl_wr),
        .prog_addr   (prog_addr),
        .prog_data   (prog_data),
        .prog_mask   (prog_mask),
        .prog_we     (prog_we),
        .prog_rdy    (prog_rdy),
        .prom_addr   (prom_addr),
        .prom_din    (prom_din),
        .prom_we     (prom_we),
        .dwnld_done  (dwnld_done),
        .overrun     (overrun)
    );

    typedef struct {
        logic [21:0] a;
        logic [7:0]  d;
        logic [1:0]  m;
    } sd_t;

    typedef struct {
        logic [11:0] we;
        logic [7:0]  a;
        logic [7:0]  d;
    } pr_t;

    sd_t sq[$];
    pr_t pq[$];
    sd_t me;
    pr_t mp;

    int errors = 0;
    int checks = 0;
    int n = 0;          // SDRAM writes accepted but not yet acknowledged
    bit exp_ovr = 0;
    bit flushing = 0;
    bit dl_prev = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock of stimulus; the model predicts the state right after the coming edge.
    task automatic step(input bit wr, input logic [21:0] a, input logic [7:0] d,
                        input bit rdy_req, input bit dl);
        bit          rdy, sd, pr, done;
        int          idx;
        logic [11:0] ep;
        rdy = rdy_req && (n > 0);
        sd  = 0;
        pr  = 0;
        ep  = '0;
        if (wr && dl && !flushing) begin
            if (a < PS) begin
                sd = 1;
            end else begin
                idx = int'((a - PS) >> 8);
                if (idx < 12) begin
                    pr = 1;
                    ep = 12'(1) << idx;
                end
            end
        end
        if (!dl_prev && dl) exp_ovr = 0;
        n = n - int'(rdy);
        if (sd) begin
            if (n < 2) begin
                sq.push_back('{a >> 1, d, (a[0] ? 2'b01 : 2'b10)});
                n++;
            end else begin
                exp_ovr = 1;
            end
        end
        if (pr) pq.push_back('{ep, a[7:0], d});
        done = 0;
        if (dl_prev && !dl) begin
            if (n == 0) done = 1;
            else flushing = 1;
        end else if (flushing && n == 0) begin
            done = 1;
            flushing = 0;
        end
        dl_prev = dl;

        ioctl_wr    = wr;
        ioctl_addr  = a;
        ioctl_data  = d;
        prog_rdy    = rdy;
        downloading = dl;
        @(posedge clk);
        #1;
        chk("prog_we", 32'(prog_we), 32'(n > 0));
        chk("overrun", 32'(overrun), 32'(exp_ovr));
        chk("dwnld_done", 32'(dwnld_done), 32'(done));
        chk("prom_we", 32'(prom_we), 32'(ep));
    endtask

    task automatic idle(input int cycles, input bit rdy, input bit dl);
        for (int i = 0; i < cycles; i++) step(0, '0, '0, rdy, dl);
    endtask

    task automatic check_reset_outputs();
        chk("rst_prog_we", 32'(prog_we), 32'h0);
        chk("rst_prog_mask", 32'(prog_mask), 32'h3);
        chk("rst_prog_addr", 32'(prog_addr), 32'h0);
        chk("rst_prog_data", 32'(prog_data), 32'h0);
        chk("rst_prom_we", 32'(prom_we), 32'h0);
        chk("rst_prom_addr", 32'(prom_addr), 32'h0);
        chk("rst_prom_din", 32'(prom_din), 32'h0);
        chk("rst_dwnld_done", 32'(dwnld_done), 32'h0);
        chk("rst_overrun", 32'(overrun), 32'h0);
    endtask

    // Asynchronous reset asserted mid-cycle, checked before any clock edge.
    task automatic hard_reset();
        #2;
        rst = 1;
        ioctl_wr = 0;
        prog_rdy = 0;
        downloading = 0;
        #1;
        check_reset_outputs();
        sq.delete();
        pq.delete();
        n = 0;
        exp_ovr = 0;
        flushing = 0;
        dl_prev = 0;
        @(posedge clk);
        #1;
        rst = 0;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (prog_we && prog_rdy) begin
                if (sq.size() == 0) begin
                    chk("sdram_unexpected_write", 32'(prog_addr), 32'hFFFF_FFFF);
                end else begin
                    me = sq.pop_front();
                    chk("prog_addr", 32'(prog_addr), 32'(me.a));
                    chk("prog_data", 32'(prog_data), 32'(me.d));
                    chk("prog_mask", 32'(prog_mask), 32'(me.m));
                end
            end
            if (prom_we != '0) begin
                if (pq.size() == 0) begin
                    chk("prom_unexpected_write", 32'(prom_we), 32'h0);
                end else begin
                    mp = pq.pop_front();
                    chk("prom_sel", 32'(prom_we), 32'(mp.we));
                    chk("prom_addr", 32'(prom_addr), 32'(mp.a));
                    chk("prom_din", 32'(prom_din), 32'(mp.d));
                end
            end
        end
    end

    logic [21:0] ra;
    int          kind;

    initial begin
        rst = 1;
        downloading = 0;
        ioctl_addr = '0;
        ioctl_data = '0;
        ioctl_wr = 0;
        prog_rdy = 0;
        #1;
        check_reset_outputs();
        repeat (2) @(posedge clk);
        #1;
        rst = 0;

        // Single odd byte, ack four cycles after the write appears
        step(1, 22'h3, 8'h5A, 0, 1);
        idle(3, 0, 1);
        step(0, '0, '0, 1, 1);
        idle(2, 0, 1);

        // Two bytes through the skid slot, slow ack
        step(1, 22'h100, 8'h11, 0, 1);
        idle(1, 0, 1);
        step(1, 22'h101, 8'h22, 0, 1);
        idle(3, 0, 1);
        step(0, '0, '0, 1, 1);
        idle(2, 0, 1);
        step(0, '0, '0, 1, 1);
        idle(2, 0, 1);

        // Overrun on the third byte, sticky through drain until downloading rises
        step(1, 22'h200, 8'hA1, 0, 1);
        idle(1, 0, 1);
        step(1, 22'h201, 8'hA2, 0, 1);
        idle(1, 0, 1);
        step(1, 22'h202, 8'hA3, 0, 1);
        idle(2, 0, 1);
        idle(1, 0, 0);
        idle(4, 1, 0);
        idle(2, 0, 0);
        idle(2, 0, 1);

        // PROM write to the second PROM
        step(1, PS + 22'h105, 8'hC3, 0, 1);
        chk("prom1_sel", 32'(prom_we), 32'h002);
        chk("prom1_addr", 32'(prom_addr), 32'h05);
        chk("prom1_din", 32'(prom_din), 32'hC3);
        idle(2, 0, 1);

        // Just past the last PROM
        step(1, PS + 22'(12 << 8), 8'h77, 0, 1);
        idle(2, 0, 1);

        // Downloading falls with both slots occupied
        step(1, 22'h300, 8'hB0, 0, 1);
        idle(1, 0, 1);
        step(1, 22'h301, 8'hB1, 0, 1);
        idle(1, 0, 0);
        idle(2, 0, 0);
        step(0, '0, '0, 1, 0);
        idle(1, 0, 0);
        step(0, '0, '0, 1, 0);
        idle(3, 0, 0);

        // Reset during a pending write
        idle(1, 0, 1);
        step(1, 22'h400, 8'hEE, 0, 1);
        idle(1, 0, 1);
        hard_reset();
        idle(3, 0, 0);

        // Randomized traffic with periodic end-of-download drains
        for (int i = 0; i < 3000; i++) begin
            if (i % 400 == 399) begin
                idle($urandom_range(1, 3), 0, 0);
                idle(4, 1, 0);
                idle($urandom_range(1, 3), 0, 0);
            end else begin
                kind = int'($urandom_range(0, 9));
                if (kind < 7)      ra = 22'($urandom_range(0, 32'(PS) - 1));
                else if (kind < 9) ra = PS + 22'($urandom_range(0, 12 * 256 - 1));
                else               ra = PS + 22'(12 * 256) + 22'($urandom_range(0, 1000));
                step($urandom_range(0, 3) == 0, ra, 8'($urandom),
                     $urandom_range(0, 2) == 0, 1);
            end
        end

        idle(1, 0, 0);
        idle(4, 1, 0);
        idle(3, 0, 0);
        chk("sdram_queue_empty", 32'(sq.size()), 32'h0);
        chk("prom_queue_empty", 32'(pq.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
